mon_checker: RTL and testbench

Result checker at the monitor end of the arithmetic testbench. Each cycle it takes the delayed operand pair from the stimulus driver and the DUT result for the same vector. It computes the expected result, compares the two, and keeps vector and error counts. It also captures the first failing vector for readout by the host. It sits between the DUT output, the driver's monitor taps and the status/readout logic.

---
 rtl/mon_checker_pkg.sv | 14 +
 rtl/mon_checker_if.sv | 15 +
 rtl/mon_checker_sat_counter.sv | 22 ++
 rtl/mon_checker.sv | 162 ++++++++++++++++
 tb/tb_mon_checker.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mon_checker_pkg.sv
// Shared types and constants for the arithmetic result checker.
package mon_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRun,
    StHalt
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mon_checker_if.sv
// Monitor-tap bundle: operation select, delayed operands and the aligned DUT result.
interface mon_checker_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned RWIDTH = WIDTH + 1
);

    logic              op;
    logic [WIDTH-1:0]  mon_a;
    logic [WIDTH-1:0]  mon_b;
    logic [RWIDTH-1:0] dut_res;

    modport master (output op, mon_a, mon_b, dut_res);
    modport slave  (input op, mon_a, mon_b, dut_res);

endinterface

// File: rtl/mon_checker_sat_counter.sv
// Counter that sticks at all-ones; synchronous clear takes priority over increment.
module mon_checker_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_dut,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mon_checker.sv
// Compares DUT results against a reference add/subtract, counts vectors and errors,
// and captures the first failing vector.
module mon_checker
    import mon_checker_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned RWIDTH       = WIDTH + 1,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic                 clk_dut,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_halt_on_err,
    mon_checker_if.slave         mon,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic                 o_err_flag,
    output logic [CNT_WIDTH-1:0] o_vec_count,
    output logic [CNT_WIDTH-1:0] o_err_count,
    output logic [WIDTH-1:0]     o_cap_a,
    output logic [WIDTH-1:0]     o_cap_b,
    output logic [RWIDTH-1:0]    o_cap_res,
    output logic [RWIDTH-1:0]    o_cap_exp
);

    localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    state_e          state_q;
    logic [FCW-1:0]  flush_cnt_q;
    logic            busy_q;
    logic            halted_q;
    logic            err_flag_q;
    logic [WIDTH-1:0]  cap_a_q;
    logic [WIDTH-1:0]  cap_b_q;
    logic [RWIDTH-1:0] cap_res_q;
    logic [RWIDTH-1:0] cap_exp_q;

    logic [RWIDTH-1:0] exp_res;
    logic              mismatch;
    logic              start_ok;
    logic              in_run;
    logic              check_fail;

    // Zero-extended operands; subtraction wraps modulo 2^RWIDTH so the borrow shows in the MSB.
    always_comb begin
        exp_res = '0;
        if (mon.op == OP_SUB) begin
            exp_res = RWIDTH'(mon.mon_a) - RWIDTH'(mon.mon_b);
        end else begin
            exp_res = RWIDTH'(mon.mon_a) + RWIDTH'(mon.mon_b);
        end
    end

    always_comb begin
        mismatch   = (mon.dut_res != exp_res);
        start_ok   = i_start && ((state_q == StIdle) || (state_q == StHalt));
        in_run     = (state_q == StRun);
        check_fail = in_run && mismatch;
    end

    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StHalt: begin
                    if (i_start) begin
                        state_q     <= StFlush;
                        flush_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        halted_q    <= 1'b0;
                    end
                end
                StFlush: begin
                    if (i_stop) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (flush_cnt_q == FLUSH_LAST) begin
                        state_q <= StRun;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FCW'(1);
                    end
                end
                StRun: begin
                    // Stop outranks both a simultaneous start and a halting mismatch.
                    if (i_stop) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (mismatch && i_halt_on_err) begin
                        state_q  <= StHalt;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_dut or negedge reset_n) begin
        if (!reset_n) begin
            err_flag_q <= 1'b0;
            cap_a_q    <= '0;
            cap_b_q    <= '0;
            cap_res_q  <= '0;
            cap_exp_q  <= '0;
        end else if (start_ok) begin
            err_flag_q <= 1'b0;
            cap_a_q    <= '0;
            cap_b_q    <= '0;
            cap_res_q  <= '0;
            cap_exp_q  <= '0;
        end else if (check_fail) begin
            err_flag_q <= 1'b1;
            if (!err_flag_q) begin
                cap_a_q   <= mon.mon_a;
                cap_b_q   <= mon.mon_b;
                cap_res_q <= mon.dut_res;
                cap_exp_q <= exp_res;
            end
        end
    end

    mon_checker_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_vec_cnt (
        .clk_dut (clk_dut),
        .reset_n (reset_n),
        .clr     (start_ok),
        .inc     (in_run),
        .count   (o_vec_count)
    );

    mon_checker_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk_dut (clk_dut),
        .reset_n (reset_n),
        .clr     (start_ok),
        .inc     (check_fail),
        .count   (o_err_count)
    );

    assign o_busy     = busy_q;
    assign o_halted   = halted_q;
    assign o_err_flag = err_flag_q;
    assign o_cap_a    = cap_a_q;
    assign o_cap_b    = cap_b_q;
    assign o_cap_res  = cap_res_q;
    assign o_cap_exp  = cap_exp_q;

endmodule

// File: tb/tb_mon_checker.sv
// Directed bench for mon_checker: vector table plus hand-written multi-cycle sequences.
module tb_mon_checker;

    logic clk_dut = 1'b0;
    logic reset_n = 1'b0;
    logic i_start = 1'b0;
    logic i_stop = 1'b0;
    logic i_halt_on_err = 1'b0;

    mon_checker_if #(.WIDTH(32)) mon ();

    logic        busy, halted, err_flag;
    logic [31:0] vec_count, err_count, cap_a, cap_b;
    logic [32:0] cap_res, cap_exp;

    logic        s_busy, s_halted, s_err_flag;
    logic [3:0]  s_vec_count, s_err_count;
    logic [31:0] s_cap_a, s_cap_b;
    logic [32:0] s_cap_res, s_cap_exp;

    int checks = 0;
    int failures = 0;

    always #5 clk_dut = ~clk_dut;

    mon_checker #(.WIDTH(32), .CNT_WIDTH(32), .FLUSH_CYCLES(3)) dut (
        .clk_dut       (clk_dut),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_halt_on_err (i_halt_on_err),
        .mon           (mon),
        .o_busy        (busy),
        .o_halted      (halted),
        .o_err_flag    (err_flag),
        .o_vec_count   (vec_count),
        .o_err_count   (err_count),
        .o_cap_a       (cap_a),
        .o_cap_b       (cap_b),
        .o_cap_res     (cap_res),
        .o_cap_exp     (cap_exp)
    );

    mon_checker #(.WIDTH(32), .CNT_WIDTH(4), .FLUSH_CYCLES(3)) dut_sat (
        .clk_dut       (clk_dut),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_halt_on_err (i_halt_on_err),
        .mon           (mon),
        .o_busy        (s_busy),
        .o_halted      (s_halted),
        .o_err_flag    (s_err_flag),
        .o_vec_count   (s_vec_count),
        .o_err_count   (s_err_count),
        .o_cap_a       (s_cap_a),
        .o_cap_b       (s_cap_b),
        .o_cap_res     (s_cap_res),
        .o_cap_exp     (s_cap_exp)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] res;
        logic [32:0] exp;
        logic        bad;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk_dut);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic set_vec(input logic [31:0] a, input logic [31:0] b, input logic [32:0] res);
        mon.mon_a   = a;
        mon.mon_b   = b;
        mon.dut_res = res;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'h1,         33'h1_0000_0000, 33'h1_0000_0000, 1'b0};
        tbl[1] = '{1'b0, 32'h1,         32'h2,         33'h3,           33'h3,           1'b0};
        tbl[2] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 33'h0,           33'h1_0000_0000, 1'b1};
        tbl[3] = '{1'b1, 32'h5,         32'h7,         33'h1_FFFF_FFFE, 33'h1_FFFF_FFFE, 1'b0};
        tbl[4] = '{1'b1, 32'h3,         32'h1,         33'h3,           33'h2,           1'b1};
        tbl[5] = '{1'b1, 32'h0,         32'h1,         33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b1};
        tbl[6] = '{1'b1, 32'hFFFF_FFFF, 32'h0,         33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b0};
        tbl[7] = '{1'b0, 32'h0,         32'h0,         33'h1,           33'h0,           1'b1};

        mon.op = 1'b0;
        set_vec(32'h0, 32'h0, 33'h0);

        // Reset and defaults
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_vec", 64'(vec_count), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_err_flag", 64'(err_flag), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_cap_res", 64'(cap_res), 64'd0);
        set_vec(32'h4, 32'h4, 33'h1);
        repeat (3) tick();
        chk("idle_vec", 64'(vec_count), 64'd0);
        chk("idle_err", 64'(err_count), 64'd0);

        // Clean run: 10 checked vectors, stop sampled with the tenth
        mon.op = 1'b0;
        set_vec(32'hFFFF_FFFF, 32'h1, 33'h1_0000_0000);
        pulse_start();
        chk("clean_busy", 64'(busy), 64'd1);
        repeat (3) tick();
        repeat (9) tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("clean_vec", 64'(vec_count), 64'd10);
        chk("clean_err", 64'(err_count), 64'd0);
        chk("clean_flag", 64'(err_flag), 64'd0);
        chk("clean_idle", 64'(busy), 64'd0);

        // Table: one checked vector per run
        for (int i = 0; i < 8; i++) begin
            mon.op = tbl[i].op;
            set_vec(tbl[i].a, tbl[i].b, tbl[i].res);
            pulse_start();
            repeat (3) tick();
            i_stop = 1'b1;
            tick();
            i_stop = 1'b0;
            chk($sformatf("tbl%0d_vec", i), 64'(vec_count), 64'd1);
            chk($sformatf("tbl%0d_err", i), 64'(err_count), 64'(tbl[i].bad));
            chk($sformatf("tbl%0d_flag", i), 64'(err_flag), 64'(tbl[i].bad));
            chk($sformatf("tbl%0d_cap_exp", i), 64'(cap_exp),
                tbl[i].bad ? 64'(tbl[i].exp) : 64'd0);
        end

        // First-error capture with flush masking
        mon.op = 1'b1;
        i_halt_on_err = 1'b0;
        set_vec(32'h1, 32'h1, 33'h7);
        pulse_start();
        repeat (3) tick();
        chk("flush_err", 64'(err_count), 64'd0);
        chk("flush_vec", 64'(vec_count), 64'd0);
        set_vec(32'h5, 32'h7, 33'h1_FFFF_FFFE);
        tick();
        set_vec(32'h3, 32'h1, 33'h3);
        tick();
        chk("cap_err1", 64'(err_count), 64'd1);
        chk("cap_res", 64'(cap_res), 64'h3);
        chk("cap_exp", 64'(cap_exp), 64'h2);
        chk("cap_a", 64'(cap_a), 64'h3);
        chk("cap_b", 64'(cap_b), 64'h1);
        set_vec(32'h9, 32'h9, 33'h1);
        tick();
        chk("cap_err2", 64'(err_count), 64'd2);
        chk("cap_res_hold", 64'(cap_res), 64'h3);
        chk("cap_exp_hold", 64'(cap_exp), 64'h2);
        // Start and stop together in RUN: stop wins, counts retained
        set_vec(32'h9, 32'h9, 33'h0);
        i_start = 1'b1;
        i_stop = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop = 1'b0;
        chk("collide_idle", 64'(busy), 64'd0);
        chk("collide_vec", 64'(vec_count), 64'd4);
        chk("collide_err", 64'(err_count), 64'd2);

        // Halt on error at the 4th checked vector
        mon.op = 1'b0;
        i_halt_on_err = 1'b1;
        set_vec(32'h1, 32'h1, 33'h2);
        pulse_start();
        chk("restart_vec", 64'(vec_count), 64'd0);
        chk("restart_flag", 64'(err_flag), 64'd0);
        repeat (3) tick();
        repeat (3) tick();
        set_vec(32'h1, 32'h1, 33'h5);
        tick();
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_busy", 64'(busy), 64'd0);
        chk("halt_vec", 64'(vec_count), 64'd4);
        chk("halt_err", 64'(err_count), 64'd1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        tick();
        chk("halt_stop_ign", 64'(halted), 64'd1);
        chk("halt_frozen_vec", 64'(vec_count), 64'd4);
        chk("halt_frozen_err", 64'(err_count), 64'd1);
        pulse_start();
        chk("halt_restart_busy", 64'(busy), 64'd1);
        chk("halt_restart_halted", 64'(halted), 64'd0);
        chk("halt_restart_vec", 64'(vec_count), 64'd0);
        chk("halt_restart_err", 64'(err_count), 64'd0);
        chk("halt_restart_cap", 64'(cap_res), 64'd0);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("flush_stop_idle", 64'(busy), 64'd0);

        // Saturation on the 4-bit instance, then async reset mid-RUN
        i_halt_on_err = 1'b0;
        set_vec(32'h0, 32'h0, 33'h1);
        pulse_start();
        repeat (3) tick();
        repeat (20) tick();
        chk("sat_vec", 64'(s_vec_count), 64'hF);
        chk("sat_err", 64'(s_err_count), 64'hF);
        chk("wide_vec", 64'(vec_count), 64'd20);
        chk("wide_err", 64'(err_count), 64'd20);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_vec", 64'(vec_count), 64'd0);
        chk("arst_err", 64'(err_count), 64'd0);
        chk("arst_flag", 64'(err_flag), 64'd0);
        chk("arst_cap_exp", 64'(cap_exp), 64'd0);
        chk("arst_sat_vec", 64'(s_vec_count), 64'd0);
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
